sign_ext: RTL and testbench
===========================

# sign_ext

Registered immediate generator for the LEGv8 datapath. It decodes the opcode field of a 32-bit instruction, extracts the matching immediate field and sign-extends it to 64 bits. It sits between instruction fetch/decode and the ALU/branch-target adder. The output is registered on the single system clock, and a flag reports whether the opcode was recognised.

## Interface
Parameters: none.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- instruction  input  32  instruction word, bit 31 = MSB; sampled every cycle.
- imm_out  output  64  sign-extended immediate for the instruction sampled on the previous edge.
- imm_valid  output  1  high when the sampled opcode matched a supported format.

## Operation
Decode the opcode fields in the priority order below; the first match wins.
- CBZ, instruction[31:24] = 8'b10110100: imm19 = instruction[23:5]; imm_out = {{45{imm19[18]}}, imm19}.
- CBNZ, instruction[31:24] = 8'b10110101: same extraction and extension as CBZ.
- LDUR, instruction[31:21] = 11'b11111000010: imm9 = instruction[20:12]; imm_out = {{55{imm9[8]}}, imm9}.
- STUR, instruction[31:21] = 11'b11111000000: same as LDUR.
- ADDI, instruction[31:22] = 10'b1001000100: imm12 = instruction[21:10]; imm_out = {{52{imm12[11]}}, imm12}. This field is sign-extended, not zero-extended; 12'hFE9 gives -23.
- B, instruction[31:26] = 6'b000101: imm26 = instruction[25:0]; sign-extended to 64 bits.
- B.cond, instruction[31:24] = 8'b01010100: imm19 = instruction[23:5]; sign-extended to 64 bits.
- Any other opcode: imm_out = 64'h0 and imm_valid = 0.

Rules that apply to every format:
- No scaling is applied. Any shift left by 2 for branch offsets is done by the downstream adder.
- Extension is pure replication of the field MSB. There is no overflow or saturation.
- Bits of the instruction outside the opcode and immediate fields (Rt, Rn, Rd, op2) are ignored.
- Opcode comparisons are exact over the listed bit ranges. There are no don't-care bits beyond those stated; for example, 11'b10011000000 is unsupported.

## Timing
- Latency is 1 cycle. imm_out and imm_valid reflect the instruction present at the previous rising edge of clk.
- Throughput is one new instruction per cycle. There is no handshake or stall input.
- Reset: while reset is high at a rising edge, the next values are imm_out = 64'h0 and imm_valid = 0, regardless of instruction.
- The first edge with reset low loads the decode of the instruction present at that edge.
- Reset asserted mid-stream overrides the decode on that edge. There is no other internal state.
- Outputs are driven only from flops and hold stable between edges. Decode logic is purely combinational into the output register.
- X or unknown values on instruction are not required to be propagated in any defined way; the behaviour is undefined.

## Test plan
- Reset: hold reset high for 2 edges with instruction = {8'b10110100, 19'd23, 5'd1} -> imm_out = 0 and imm_valid = 0. Release reset -> next edge gives imm_out = 64'd23 and imm_valid = 1.
- CBZ/CBNZ: {8'b10110100, 19'd23, 5'd1} -> 64'd23. {8'b10110101, 19'b1111111111111101001, 5'd1} -> 64'hFFFF_FFFF_FFFF_FFE9. imm_valid = 1 in both cases.
- LDUR/STUR: {11'b11111000010, 9'd23, 12'd1} -> 64'd23. {11'b11111000000, 9'b111101001, 12'd1} -> 64'hFFFF_FFFF_FFFF_FFE9.
- ADDI: {10'b1001000100, 12'd23, 5'd1, 5'd1} -> 64'd23. {10'b1001000100, 12'hFE9, 5'd1, 5'd1} -> 64'hFFFF_FFFF_FFFF_FFE9.
- B and B.cond:
  - {6'b000101, 26'h3FFFFFF} -> 64'hFFFF_FFFF_FFFF_FFFF.
  - {8'b01010100, 19'h40000, 5'd0} -> 64'hFFFF_FFFF_FFFC_0000.
  - 26'h1FFFFFF -> 64'h0000_0000_01FF_FFFF.
- Unsupported opcode {11'b10011000000, 9'd23, 12'd1} -> imm_out = 0 and imm_valid = 0. Back-to-back alternating valid and unsupported instructions must update every cycle with exactly 1-cycle latency.

Source files
------------

// File: rtl/sign_ext.sv
// sign_ext: registered immediate generator for the LEGv8 datapath.
// Decodes the opcode of a 32-bit instruction, extracts the matching
// immediate field and sign-extends it to 64 bits, one cycle of latency.
module sign_ext (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  output logic [63:0] imm_out,
  output logic        imm_valid
);

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_CB,     // CBZ / CBNZ / B.cond: imm19 at [23:5]
    FMT_D,      // LDUR / STUR: imm9 at [20:12]
    FMT_I,      // ADDI: imm12 at [21:10]
    FMT_B       // B: imm26 at [25:0]
  } fmt_t;

  fmt_t        fmt;
  logic [63:0] imm_next;
  logic        valid_next;

  // Opcode decode in priority order; first match wins, exact bit compares.
  always_comb begin
    fmt = FMT_NONE;
    if      (instruction[31:24] == 8'b10110100)    fmt = FMT_CB;  // CBZ
    else if (instruction[31:24] == 8'b10110101)    fmt = FMT_CB;  // CBNZ
    else if (instruction[31:21] == 11'b11111000010) fmt = FMT_D;  // LDUR
    else if (instruction[31:21] == 11'b11111000000) fmt = FMT_D;  // STUR
    else if (instruction[31:22] == 10'b1001000100) fmt = FMT_I;   // ADDI
    else if (instruction[31:26] == 6'b000101)      fmt = FMT_B;   // B
    else if (instruction[31:24] == 8'b01010100)    fmt = FMT_CB;  // B.cond
  end

  // Field extraction and MSB replication; unsupported opcodes give zero.
  always_comb begin
    imm_next   = '0;
    valid_next = 1'b1;
    unique case (fmt)
      FMT_CB:  imm_next = {{45{instruction[23]}}, instruction[23:5]};
      FMT_D:   imm_next = {{55{instruction[20]}}, instruction[20:12]};
      FMT_I:   imm_next = {{52{instruction[21]}}, instruction[21:10]};
      FMT_B:   imm_next = {{38{instruction[25]}}, instruction[25:0]};
      default: begin
        imm_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // Output register; synchronous reset overrides the decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_out   <= '0;
      imm_valid <= 1'b0;
    end else begin
      imm_out   <= imm_next;
      imm_valid <= valid_next;
    end
  end

endmodule

// File: tb/tb_sign_ext.sv
// tb_sign_ext: directed bench for sign_ext using an expected-value queue.
module tb_sign_ext;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [63:0] imm_out;
  logic        imm_valid;

  sign_ext dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .imm_out     (imm_out),
    .imm_valid   (imm_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic        valid;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // Compare outputs (sampled on the falling edge) against the oldest entry.
  task automatic check_head();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      assert (imm_out === e.imm) else begin
        n_fails++;
        $error("FAIL %s imm_out: got %h expected %h", e.name, imm_out, e.imm);
      end
      n_checks++;
      assert (imm_valid === e.valid) else begin
        n_fails++;
        $error("FAIL %s imm_valid: got %b expected %b", e.name, imm_valid, e.valid);
      end
    end
  endtask

  // One cycle: check the previous result, then drive a new input and queue its expectation.
  task automatic step(input logic rst, input logic [31:0] ins,
                      input logic [63:0] ei, input logic ev, input string name);
    exp_t e;
    @(negedge clk);
    check_head();
    reset       = rst;
    instruction = ins;
    e.imm   = ei;
    e.valid = ev;
    e.name  = name;
    sb.push_back(e);
  endtask

  logic [11:0]        r12;
  logic [9:0]         rregs;
  logic [20:0]        rlow;
  logic signed [63:0] sx;

  initial begin
    reset       = 1'b1;
    instruction = '0;

    // Reset held for two edges with a valid CBZ present.
    step(1'b1, {8'b10110100, 19'd23, 5'd1}, 64'h0, 1'b0, "reset0");
    step(1'b1, {8'b10110100, 19'd23, 5'd1}, 64'h0, 1'b0, "reset1");
    step(1'b0, {8'b10110100, 19'd23, 5'd1}, 64'd23, 1'b1, "release_cbz");

    step(1'b0, {8'b10110101, 19'b1111111111111101001, 5'd1},
         64'hFFFF_FFFF_FFFF_FFE9, 1'b1, "cbnz_neg");
    step(1'b0, {8'b10110100, 19'h3FFFF, 5'd7},
         64'h0000_0000_0003_FFFF, 1'b1, "cbz_maxpos");
    step(1'b0, {11'b11111000010, 9'd23, 12'd1}, 64'd23, 1'b1, "ldur_pos");
    step(1'b0, {11'b11111000000, 9'b111101001, 12'd1},
         64'hFFFF_FFFF_FFFF_FFE9, 1'b1, "stur_neg");
    step(1'b0, {10'b1001000100, 12'd23, 5'd1, 5'd1}, 64'd23, 1'b1, "addi_pos");
    step(1'b0, {10'b1001000100, 12'hFE9, 5'd1, 5'd1},
         64'hFFFF_FFFF_FFFF_FFE9, 1'b1, "addi_neg");
    step(1'b0, {6'b000101, 26'h3FFFFFF}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, "b_allones");
    step(1'b0, {6'b000101, 26'h1FFFFFF}, 64'h0000_0000_01FF_FFFF, 1'b1, "b_maxpos");
    step(1'b0, {8'b01010100, 19'h40000, 5'd0},
         64'hFFFF_FFFF_FFFC_0000, 1'b1, "bcond_minneg");
    step(1'b0, {11'b10011000000, 9'd23, 12'd1}, 64'h0, 1'b0, "unsupported");
    step(1'b0, {11'b11111000001, 9'd23, 12'd1}, 64'h0, 1'b0, "near_stur");
    step(1'b0, {6'b000100, 26'h1234567}, 64'h0, 1'b0, "near_b");

    // Back-to-back alternating ADDI (random imm and regs) and unsupported words.
    for (int unsigned i = 0; i < 8; i++) begin
      r12   = 12'($urandom);
      rregs = 10'($urandom);
      sx    = $signed(r12);
      step(1'b0, {10'b1001000100, r12, rregs}, sx, 1'b1, "alt_addi");
      rlow  = 21'($urandom);
      step(1'b0, {11'b10011000000, rlow}, 64'h0, 1'b0, "alt_unsup");
    end

    // Reset mid-stream overrides decode, then the stream resumes.
    step(1'b0, {8'b10110101, 19'd5, 5'd3}, 64'd5, 1'b1, "pre_reset");
    step(1'b1, {11'b11111000010, 9'd99, 12'd0}, 64'h0, 1'b0, "mid_reset");
    step(1'b0, {11'b11111000010, 9'd99, 12'd0}, 64'd99, 1'b1, "post_reset");

    // Drain the final queued expectation.
    @(negedge clk);
    check_head();
    n_checks++;
    assert (sb.size() == 0) else begin
      n_fails++;
      $error("FAIL drain: queue size %0d expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
